// File: rtl/uart_cmd_framer.sv
// uart_cmd_framer: assembles SYNC/CMD/ARG_HI/ARG_LO/CHK byte frames into held commands
//   i_Clock, i_Reset          : clock, synchronous active-high reset
//   i_Rx_DV, i_Rx_Byte        : byte strobe and byte from the UART receiver
//   i_Cmd_Ack                 : consumer accepts the presented command
//   o_Cmd_Valid, o_Cmd, o_Arg : held command, stable until acknowledged
//   o_Err, o_Err_Code         : one-cycle error strobe, last cause (01 chk, 10 timeout, 11 overrun)
//   o_Busy                    : a frame is partially received
`timescale 1ns/1ps
module uart_cmd_framer #(
    parameter int TIMEOUT_CLKS = 8680
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_Rx_DV,
    input  logic [7:0]  i_Rx_Byte,
    input  logic        i_Cmd_Ack,
    output logic        o_Cmd_Valid,
    output logic [7:0]  o_Cmd,
    output logic [15:0] o_Arg,
    output logic        o_Err,
    output logic [1:0]  o_Err_Code,
    output logic        o_Busy
);
    localparam int CW = $clog2(TIMEOUT_CLKS + 1);
    typedef enum logic [2:0] {S_SYNC, S_CMD, S_ARG_HI, S_ARG_LO, S_CHK} state_t;
    state_t          state;
    logic [CW-1:0]   idle_cnt;
    logic [7:0]      sum, sh_cmd, sh_hi, sh_lo;
    logic            timeout;
    // fires on the edge where the idle counter reaches TIMEOUT_CLKS-1
    assign timeout = (state != S_SYNC) && !i_Rx_DV && (idle_cnt == CW'(TIMEOUT_CLKS - 2));
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state       <= S_SYNC;
            idle_cnt    <= '0;
            sum         <= '0;
            sh_cmd      <= '0;
            sh_hi       <= '0;
            sh_lo       <= '0;
            o_Cmd_Valid <= 1'b0;
            o_Cmd       <= '0;
            o_Arg       <= '0;
            o_Err       <= 1'b0;
            o_Err_Code  <= 2'b00;
            o_Busy      <= 1'b0;
        end else begin
            o_Err    <= 1'b0;
            idle_cnt <= (i_Rx_DV || state == S_SYNC) ? '0 :
                        (idle_cnt == {CW{1'b1}}) ? idle_cnt : idle_cnt + 1'b1;
            if (o_Cmd_Valid && i_Cmd_Ack)
                o_Cmd_Valid <= 1'b0;
            if (i_Rx_DV) begin
                case (state)
                    S_SYNC: begin
                        sum    <= '0;
                        state  <= (i_Rx_Byte == 8'hA5) ? S_CMD : S_SYNC;
                        o_Busy <= (i_Rx_Byte == 8'hA5);
                    end
                    S_CMD: begin
                        sh_cmd <= i_Rx_Byte;
                        sum    <= i_Rx_Byte;
                        state  <= S_ARG_HI;
                    end
                    S_ARG_HI: begin
                        sh_hi <= i_Rx_Byte;
                        sum   <= sum + i_Rx_Byte;
                        state <= S_ARG_LO;
                    end
                    S_ARG_LO: begin
                        sh_lo <= i_Rx_Byte;
                        sum   <= sum + i_Rx_Byte;
                        state <= S_CHK;
                    end
                    S_CHK: begin
                        state  <= S_SYNC;
                        o_Busy <= 1'b0;
                        if (i_Rx_Byte != sum) begin
                            o_Err      <= 1'b1;
                            o_Err_Code <= 2'b01;
                        end else if (o_Cmd_Valid && !i_Cmd_Ack) begin
                            // held command wins; the new one is dropped
                            o_Err      <= 1'b1;
                            o_Err_Code <= 2'b11;
                        end else begin
                            o_Cmd_Valid <= 1'b1;
                            o_Cmd       <= sh_cmd;
                            o_Arg       <= {sh_hi, sh_lo};
                        end
                    end
                    default: begin
                        state  <= S_SYNC;
                        o_Busy <= 1'b0;
                    end
                endcase
            end else if (timeout) begin
                state      <= S_SYNC;
                o_Busy     <= 1'b0;
                o_Err      <= 1'b1;
                o_Err_Code <= 2'b10;
            end
        end
    end
endmodule

// File: tb/tb_uart_cmd_framer.sv
`timescale 1ns/1ps
module tb_uart_cmd_framer;
    localparam int T = 16;
    logic        clk = 1'b0, rst = 1'b0, dv = 1'b0, ack = 1'b0;
    logic [7:0]  rx_byte = '0;
    logic        cmd_valid, err, busy;
    logic [7:0]  cmd;
    logic [15:0] arg;
    logic [1:0]  err_code;
    int          n = 0, fails = 0;

    uart_cmd_framer #(.TIMEOUT_CLKS(T)) dut (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_DV(dv), .i_Rx_Byte(rx_byte),
        .i_Cmd_Ack(ack), .o_Cmd_Valid(cmd_valid), .o_Cmd(cmd), .o_Arg(arg),
        .o_Err(err), .o_Err_Code(err_code), .o_Busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        dv = 1'b1;
        rx_byte = b;
        tick();
        dv = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] k);
        send(8'hA5); send(c); send(hi); send(lo); send(k);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_valid", 16'(cmd_valid), 16'h0);
        chk("rst_cmd", 16'(cmd), 16'h0);
        chk("rst_arg", arg, 16'h0);
        chk("rst_err", 16'(err), 16'h0);
        chk("rst_code", 16'(err_code), 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);

        // good frame, ack three cycles after CHK
        send(8'hA5);
        chk("good_busy_sync", 16'(busy), 16'h1);
        send(8'h10); send(8'h12); send(8'h34); send(8'h56);
        chk("good_valid", 16'(cmd_valid), 16'h1);
        chk("good_cmd", 16'(cmd), 16'h10);
        chk("good_arg", arg, 16'h1234);
        chk("good_err", 16'(err), 16'h0);
        chk("good_busy", 16'(busy), 16'h0);
        tick(); tick();
        chk("good_hold_valid", 16'(cmd_valid), 16'h1);
        chk("good_hold_arg", arg, 16'h1234);
        do_ack();
        chk("good_ack_clear", 16'(cmd_valid), 16'h0);

        // noise then frame with A5 as CMD and bad checksum
        send(8'h00);
        chk("noise00_err", 16'(err), 16'h0);
        chk("noise00_busy", 16'(busy), 16'h0);
        send(8'hFF);
        chk("noiseFF_err", 16'(err), 16'h0);
        send_frame(8'hA5, 8'h01, 8'h02, 8'h06);
        chk("noise_chk_err", 16'(err), 16'h1);
        chk("noise_chk_code", 16'(err_code), 16'h1);
        chk("noise_chk_valid", 16'(cmd_valid), 16'h0);
        tick();
        chk("noise_err_pulse", 16'(err), 16'h0);
        chk("noise_code_hold", 16'(err_code), 16'h1);
        send_frame(8'hA5, 8'h01, 8'h02, 8'hA8);
        chk("noise_ok_valid", 16'(cmd_valid), 16'h1);
        chk("noise_ok_cmd", 16'(cmd), 16'hA5);
        chk("noise_ok_arg", arg, 16'h0102);
        do_ack();
        chk("noise_ack_clear", 16'(cmd_valid), 16'h0);
        do_ack();
        chk("idle_ack_ignored", 16'(cmd_valid), 16'h0);

        // checksum error
        send_frame(8'h10, 8'h12, 8'h34, 8'h57);
        chk("chk_err", 16'(err), 16'h1);
        chk("chk_code", 16'(err_code), 16'h1);
        chk("chk_valid", 16'(cmd_valid), 16'h0);
        chk("chk_busy", 16'(busy), 16'h0);

        // timeout after A5 10
        send(8'hA5); send(8'h10);
        repeat (T - 2) @(posedge clk);
        #1;
        chk("to_early_err", 16'(err), 16'h0);
        chk("to_early_busy", 16'(busy), 16'h1);
        tick();
        chk("to_err", 16'(err), 16'h1);
        chk("to_code", 16'(err_code), 16'h2);
        chk("to_busy", 16'(busy), 16'h0);
        tick();
        chk("to_err_pulse", 16'(err), 16'h0);
        send_frame(8'h01, 8'h00, 8'h02, 8'h03);
        chk("to_next_valid", 16'(cmd_valid), 16'h1);
        chk("to_next_cmd", 16'(cmd), 16'h01);
        chk("to_next_arg", arg, 16'h0002);
        do_ack();

        // overrun: second frame while first is held
        send_frame(8'h10, 8'h12, 8'h34, 8'h56);
        chk("ovr_first_valid", 16'(cmd_valid), 16'h1);
        send_frame(8'h20, 8'h00, 8'h01, 8'h21);
        chk("ovr_err", 16'(err), 16'h1);
        chk("ovr_code", 16'(err_code), 16'h3);
        chk("ovr_valid", 16'(cmd_valid), 16'h1);
        chk("ovr_cmd_held", 16'(cmd), 16'h10);
        chk("ovr_arg_held", arg, 16'h1234);
        // ack coincident with CHK strobe loads the new command
        send(8'hA5); send(8'h30); send(8'h00); send(8'h05);
        ack = 1'b1;
        send(8'h35);
        ack = 1'b0;
        chk("coin_valid", 16'(cmd_valid), 16'h1);
        chk("coin_cmd", 16'(cmd), 16'h30);
        chk("coin_arg", arg, 16'h0005);
        chk("coin_err", 16'(err), 16'h0);
        chk("coin_code", 16'(err_code), 16'h3);
        do_ack();
        chk("coin_ack_clear", 16'(cmd_valid), 16'h0);

        // reset mid-frame with a command pending, DV during reset ignored
        send_frame(8'h10, 8'h12, 8'h34, 8'h56);
        send(8'hA5); send(8'h10); send(8'h12);
        rst = 1'b1;
        dv = 1'b1;
        rx_byte = 8'hA5;
        tick();
        rst = 1'b0;
        dv = 1'b0;
        chk("mid_rst_valid", 16'(cmd_valid), 16'h0);
        chk("mid_rst_cmd", 16'(cmd), 16'h0);
        chk("mid_rst_arg", arg, 16'h0);
        chk("mid_rst_err", 16'(err), 16'h0);
        chk("mid_rst_code", 16'(err_code), 16'h0);
        chk("mid_rst_busy", 16'(busy), 16'h0);
        send_frame(8'h20, 8'h00, 8'h01, 8'h21);
        chk("post_rst_valid", 16'(cmd_valid), 16'h1);
        chk("post_rst_cmd", 16'(cmd), 16'h20);
        chk("post_rst_arg", arg, 16'h0001);
        chk("post_rst_err", 16'(err), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n, fails);
        $finish;
    end
endmodule
